input_conditioner: RTL and testbench

Parametrised, multi-channel front end for raw board inputs such as push-buttons and switches, clocked on the CPU clock. Per channel it synchronises the input, debounces it with a shared sample tick and a saturating qualify counter, and produces an output chosen at run time. Output modes are rising-edge pulse, falling-edge pulse, debounced level, or auto-repeat pulse train. It generalises the single-mode button parser and feeds reset logic and CPU-visible I/O.

---
 rtl/input_conditioner_pkg.sv | 20 ++
 rtl/input_conditioner_channel.sv | 128 ++++++++++++
 rtl/input_conditioner.sv | 61 ++++++
 tb/tb_input_conditioner.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/input_conditioner_pkg.sv
// Shared encodings for the input conditioner: run-time output modes and
// the per-channel auto-repeat state machine.
package input_conditioner_pkg;

    typedef enum logic [1:0] {
        MODE_RISE   = 2'b00,
        MODE_FALL   = 2'b01,
        MODE_LEVEL  = 2'b10,
        MODE_REPEAT = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'b00,
        RPT_DELAY  = 2'b01,
        RPT_REPEAT = 2'b10
    } rpt_state_e;

    localparam int unsigned RCNT_W = 16;

endpackage

// File: rtl/input_conditioner_channel.sv
// One conditioner channel: synchroniser, tick-sampled qualify counter,
// edge history, auto-repeat FSM and run-time output mode select.
module input_conditioner_channel
    import input_conditioner_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned PULSE_CNT_MAX = 200,
    parameter int unsigned REPEAT_DELAY  = 1000,
    parameter int unsigned REPEAT_RATE   = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_i,
    input  logic       in_i,
    input  logic [1:0] mode_i,
    output logic       debounced_o,
    output logic       out_o
);

    localparam int unsigned PW = $clog2(PULSE_CNT_MAX + 1);
    localparam logic [PW-1:0]     PCNT_MAX   = PW'(PULSE_CNT_MAX);
    localparam logic [RCNT_W-1:0] DELAY_LAST = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] RATE_LAST  = RCNT_W'(REPEAT_RATE - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [PW-1:0]          pcnt_q, pcnt_d;
    logic                   deb_q, deb_d;
    logic                   d_q;
    logic                   rise, fall;
    rpt_state_e             state_q;
    logic [RCNT_W-1:0]      rcnt_q;
    logic                   rep_q;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        pcnt_d = pcnt_q;
        if (tick_i) begin
            if (!s) begin
                pcnt_d = '0;
            end else if (pcnt_q != PCNT_MAX) begin
                pcnt_d = pcnt_q + PW'(1);
            end
        end
        deb_d = (pcnt_d == PCNT_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            pcnt_q <= '0;
            deb_q  <= 1'b0;
            d_q    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
            pcnt_q <= pcnt_d;
            deb_q  <= deb_d;
            d_q    <= deb_q;
        end
    end

    assign rise = deb_q & ~d_q;
    assign fall = ~deb_q & d_q;

    // Release is judged on the next debounced value so a drop landing on a
    // repeat tick suppresses that tick's pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RPT_IDLE;
            rcnt_q  <= '0;
            rep_q   <= 1'b0;
        end else begin
            rep_q <= 1'b0;
            if (!deb_d) begin
                state_q <= RPT_IDLE;
                rcnt_q  <= '0;
            end else begin
                case (state_q)
                    RPT_IDLE: begin
                        if (rise) begin
                            state_q <= RPT_DELAY;
                            rcnt_q  <= '0;
                        end
                    end
                    RPT_DELAY: begin
                        if (tick_i) begin
                            if (rcnt_q == DELAY_LAST) begin
                                rep_q   <= 1'b1;
                                state_q <= RPT_REPEAT;
                                rcnt_q  <= '0;
                            end else begin
                                rcnt_q <= rcnt_q + RCNT_W'(1);
                            end
                        end
                    end
                    RPT_REPEAT: begin
                        if (tick_i) begin
                            if (rcnt_q == RATE_LAST) begin
                                rep_q  <= 1'b1;
                                rcnt_q <= '0;
                            end else begin
                                rcnt_q <= rcnt_q + RCNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_q <= RPT_IDLE;
                        rcnt_q  <= '0;
                    end
                endcase
            end
        end
    end

    assign debounced_o = deb_q;

    always_comb begin
        out_o = 1'b0;
        case (mode_e'(mode_i))
            MODE_RISE:   out_o = rise;
            MODE_FALL:   out_o = fall;
            MODE_LEVEL:  out_o = deb_q;
            MODE_REPEAT: out_o = rise | rep_q;
        endcase
    end

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: shared sample-tick counter feeding
// WIDTH independent debounce/edge/repeat channels.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int unsigned WIDTH          = 4,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned SAMPLE_CNT_MAX = 25000,
    parameter int unsigned PULSE_CNT_MAX  = 200,
    parameter int unsigned REPEAT_DELAY   = 1000,
    parameter int unsigned REPEAT_RATE    = 100
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in,
    input  logic [2*WIDTH-1:0]   mode,
    output logic [WIDTH-1:0]     debounced,
    output logic [WIDTH-1:0]     out,
    output logic                 any_pressed
);

    localparam int unsigned SCW = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
    localparam logic [SCW-1:0] SCNT_LAST = SCW'(SAMPLE_CNT_MAX - 1);

    logic [SCW-1:0] scnt_q, scnt_d;
    logic           tick;

    assign tick = (scnt_q == SCNT_LAST);

    always_comb begin
        scnt_d = tick ? '0 : scnt_q + SCW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scnt_q <= '0;
        end else begin
            scnt_q <= scnt_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        input_conditioner_channel #(
            .SYNC_STAGES   (SYNC_STAGES),
            .PULSE_CNT_MAX (PULSE_CNT_MAX),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_RATE   (REPEAT_RATE)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .tick_i      (tick),
            .in_i        (in[i]),
            .mode_i      (mode[2*i+1 -: 2]),
            .debounced_o (debounced[i]),
            .out_o       (out[i])
        );
    end

    assign any_pressed = |debounced;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with short tick/qualify/repeat constants.
module tb_input_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] in;
    logic [3:0] mode;
    logic [1:0] debounced;
    logic [1:0] out;
    logic       any_pressed;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    input_conditioner #(
        .WIDTH          (2),
        .SYNC_STAGES    (2),
        .SAMPLE_CNT_MAX (4),
        .PULSE_CNT_MAX  (3),
        .REPEAT_DELAY   (5),
        .REPEAT_RATE    (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in          (in),
        .mode        (mode),
        .debounced   (debounced),
        .out         (out),
        .any_pressed (any_pressed)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // One clock, sampled on the falling edge after it.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int       lat, lat1, pulses, pulse_at, o0, o1;
        logic [2:0] hi;
        int       pt[$];
        int       pt2[$];

        rst  = 1'b1;
        in   = '0;
        mode = '0;
        repeat (3) @(negedge clk);
        check("rst_deb", debounced, 0);
        check("rst_out", out, 0);
        check("rst_any", any_pressed, 0);
        in   = 2'b11;
        mode = 4'b1010;
        repeat (4) @(negedge clk);
        check("rst_level_out", out, 0);
        in   = '0;
        mode = '0;
        rst  = 1'b0;
        repeat (20) cyc();

        // Clean press, rise mode
        mode = 4'b0000;
        in[0] = 1'b1;
        lat = -1; pulses = 0; pulse_at = -1;
        for (int n = 1; n <= 40; n++) begin
            cyc();
            if (debounced[0] && lat < 0) lat = n;
            if (out[0]) begin pulses++; pulse_at = n; end
        end
        check("press_lat_in_11_15", int'(lat >= 11 && lat <= 15), 1);
        check("press_pulse_cnt", pulses, 1);
        check("press_pulse_at_rise", pulse_at, lat);
        check("press_any", any_pressed, 1);
        check("press_deb", debounced, 1);
        in[0] = 1'b0;
        repeat (10) cyc();
        check("release_deb", debounced, 0);
        repeat (10) cyc();

        // Glitch rejection, level mode on channel 0
        mode = 4'b0010;
        hi = '0;
        for (int r = 0; r < 4; r++) begin
            in[0] = 1'b1;
            for (int k = 0; k < 8; k++) begin cyc(); hi |= {debounced[0], out[0], any_pressed}; end
            in[0] = 1'b0;
            for (int k = 0; k < 4; k++) begin cyc(); hi |= {debounced[0], out[0], any_pressed}; end
        end
        for (int k = 0; k < 8; k++) begin cyc(); hi |= {debounced[0], out[0], any_pressed}; end
        check("glitch_deb", hi[2], 0);
        check("glitch_out", hi[1], 0);
        check("glitch_any", hi[0], 0);

        // Fall mode
        mode = 4'b0001;
        in[0] = 1'b1;
        pulses = 0;
        for (int n = 1; n <= 30; n++) begin cyc(); pulses += int'(out[0]); end
        check("fall_press_no_out", pulses, 0);
        check("fall_held_deb", debounced[0], 1);
        in[0] = 1'b0;
        lat = -1; pulses = 0;
        for (int n = 1; n <= 15; n++) begin
            cyc();
            if (out[0]) begin pulses++; if (lat < 0) lat = n; end
        end
        check("fall_pulse_cnt", pulses, 1);
        check("fall_lat_in_3_7", int'(lat >= 3 && lat <= 7), 1);
        check("fall_deb_low", debounced[0], 0);
        repeat (10) cyc();

        // Auto-repeat
        mode = 4'b0011;
        in[0] = 1'b1;
        lat = -1;
        for (int n = 1; n <= 80; n++) begin
            cyc();
            if (debounced[0] && lat < 0) lat = n;
            if (out[0]) pt.push_back(n);
        end
        check("rep_pulse_cnt_ge6", int'(pt.size() >= 6), 1);
        if (pt.size() >= 3) begin
            check("rep_first_at_rise", pt[0], lat);
            check("rep_first_gap", pt[1] - pt[0], 20);
            for (int k = 2; k < pt.size(); k++) check("rep_gap", pt[k] - pt[k-1], 8);
        end
        in[0] = 1'b0;
        pulses = 0;
        for (int n = 1; n <= 30; n++) begin
            cyc();
            if (out[0] && !debounced[0]) pulses++;
        end
        check("rep_release_no_pulse", pulses, 0);
        check("rep_release_deb", debounced[0], 0);
        in[0] = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            cyc();
            if (out[0]) pt2.push_back(n);
        end
        check("rep_restart_cnt_ge2", int'(pt2.size() >= 2), 1);
        if (pt2.size() >= 2) check("rep_restart_gap", pt2[1] - pt2[0], 20);
        in[0] = 1'b0;
        repeat (20) cyc();

        // Reset mid-press on channel 1
        mode = 4'b0000;
        in[1] = 1'b1;
        lat = -1;
        for (int n = 1; n <= 30; n++) begin
            cyc();
            if (debounced[1] && lat < 0) lat = n;
        end
        check("rmp_pre_deb", debounced[1], 1);
        rst = 1'b1;
        #1;
        check("rmp_async_deb", debounced, 0);
        check("rmp_async_any", any_pressed, 0);
        for (int n = 0; n < 3; n++) begin
            cyc();
            check("rmp_hold_out", {debounced, out, any_pressed}, 0);
        end
        rst = 1'b0;
        lat = -1; pulses = 0;
        for (int n = 1; n <= 30; n++) begin
            cyc();
            if (debounced[1] && lat < 0) lat = n;
            if (out[1]) pulses++;
        end
        check("rmp_requal_lat", lat, 12);
        check("rmp_rise_cnt", pulses, 1);
        in[1] = 1'b0;
        repeat (20) cyc();

        // Independence: ch0 level, ch1 rise, pressed together
        mode = 4'b0010;
        in = 2'b11;
        lat = -1; lat1 = -1; o0 = 0; o1 = 0;
        for (int n = 1; n <= 40; n++) begin
            cyc();
            if (debounced[0] && lat < 0) lat = n;
            if (debounced[1] && lat1 < 0) lat1 = n;
            o0 += int'(out[0]);
            o1 += int'(out[1]);
        end
        check("indep_same_cycle", lat1, lat);
        check("indep_level_cnt", o0, 41 - lat);
        check("indep_rise_cnt", o1, 1);
        check("indep_deb", debounced, 3);
        mode = 4'b0000;
        pulses = 0;
        for (int n = 1; n <= 10; n++) begin cyc(); pulses += int'(out[0]) + int'(out[1]); end
        check("mode_switch_no_pulse", pulses, 0);
        check("mode_switch_deb_kept", debounced, 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
